// File: rtl/mlaccel_qpi_pkg.sv
// Shared definitions for the host-side QPI initiator: FSM state encoding,
// accelerator command opcodes and divider limits.
package mlaccel_qpi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_GAP  = 3'd1,
        ST_LEAD = 3'd2,
        ST_LOW  = 3'd3,
        ST_HIGH = 3'd4,
        ST_WAIT = 3'd5,
        ST_TAIL = 3'd6
    } qpi_state_e;

    localparam logic [7:0] CMD_STATUS    = 8'h20;
    localparam logic [7:0] CMD_CONFIG    = 8'h21;
    localparam logic [7:0] CMD_WR_DATA   = 8'h22;
    localparam logic [7:0] CMD_RD_DATA   = 8'h23;
    localparam logic [7:0] CMD_WR_WEIGHT = 8'h24;
    localparam logic [7:0] CMD_START     = 8'h25;
    localparam logic [7:0] CMD_STOP      = 8'h26;

    localparam int CLKDIV_MIN = 4;

endpackage

// File: rtl/mlaccel_qpi_master_divcnt.sv
// Loadable 8-bit down-counter with a terminal-count flag; sticks at zero
// instead of wrapping so a late reload can never be missed.
module mlaccel_qpi_divcnt (
    input  logic       clock,
    input  logic       resetn,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    output logic       o_tc
);

    logic [7:0] r_cnt;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= 8'd0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    assign o_tc = (r_cnt == 8'd0);

endmodule

// File: rtl/mlaccel_qpi_master.sv
// Host-side QPI initiator: turns a byte request stream into CSB/CLK/IO pin
// activity and returns read bytes. Every pin is a flop loaded from next state.
module mlaccel_qpi_master
    import mlaccel_qpi_pkg::*;
#(
    parameter int CLKDIV  = 4,
    parameter int CSB_GAP = 8
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       xfer_valid,
    output logic       xfer_ready,
    input  logic       xfer_start,
    input  logic       xfer_last,
    input  logic       xfer_dir,
    input  logic [7:0] xfer_data,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       qpi_csb_do,
    output logic       qpi_clk_do,
    output logic [3:0] qpi_io_do,
    output logic [3:0] qpi_io_oe,
    input  logic [3:0] qpi_io_di
);

    localparam int         DIV_EFF = (CLKDIV < CLKDIV_MIN) ? CLKDIV_MIN : CLKDIV;
    localparam logic [7:0] DIV_M1  = 8'(DIV_EFF - 1);
    localparam logic [7:0] GAP_M1  = 8'(CSB_GAP - 1);

    qpi_state_e r_state, w_next;
    logic       w_tc, w_accept, w_start_eff, w_dir, w_load;
    logic [7:0] w_byte, w_load_val;

    logic       r_ready, r_busy, r_csb, r_clk, r_oe;
    logic [3:0] r_do;
    logic [7:0] r_data, r_rx, r_rd_data;
    logic       r_dir, r_last, r_pend, r_rd_seen, r_rd_pend, r_rd_valid;

    // Handshake: a byte moves when xfer_valid && xfer_ready on a rising clock.
    assign w_accept = xfer_valid && r_ready;
    assign w_dir    = w_accept ? xfer_dir : r_dir;
    assign w_byte   = w_accept ? xfer_data : r_data;
    // Once the slave has driven IO in this frame, a write must reopen the frame.
    assign w_start_eff = xfer_start || (r_rd_seen && !xfer_dir);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_GAP;
            ST_GAP:  if (w_tc) w_next = r_pend ? ST_LEAD : ST_IDLE;
            ST_LEAD: if (w_tc) w_next = ST_LOW;
            ST_LOW:  if (w_tc) w_next = ST_HIGH;
            ST_HIGH: if (w_tc) w_next = r_last ? ST_TAIL : ST_WAIT;
            ST_WAIT: if (w_accept) w_next = w_start_eff ? ST_GAP : ST_LOW;
            ST_TAIL: if (w_tc) w_next = ST_GAP;
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_load     = (w_next != r_state);
    assign w_load_val = (w_next == ST_GAP) ? GAP_M1 : DIV_M1;

    mlaccel_qpi_divcnt u_divcnt (
        .clock      (clock),
        .resetn     (resetn),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_tc       (w_tc)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_csb      <= 1'b1;
            r_clk      <= 1'b0;
            r_oe       <= 1'b0;
            r_do       <= 4'h0;
            r_data     <= 8'h00;
            r_dir      <= 1'b0;
            r_last     <= 1'b0;
            r_pend     <= 1'b0;
            r_rd_seen  <= 1'b0;
            r_rx       <= 8'h00;
            r_rd_pend  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= 8'h00;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next == ST_IDLE) || (w_next == ST_WAIT);
            r_busy  <= (w_next != ST_IDLE);
            r_csb   <= (w_next == ST_IDLE) || (w_next == ST_GAP);
            r_clk   <= (w_next == ST_HIGH);

            if (w_accept) begin
                r_data <= xfer_data;
                r_dir  <= xfer_dir;
                r_last <= xfer_last;
                r_pend <= 1'b1;
            end
            if (w_load && (w_next == ST_LOW)) begin
                r_pend <= 1'b0;
                r_oe   <= !w_dir;
                r_do   <= w_dir ? 4'h0 : w_byte[7:4];
                if (w_dir) r_rd_seen <= 1'b1;
            end
            if (w_load && (w_next == ST_HIGH)) begin
                r_do <= r_dir ? 4'h0 : r_data[3:0];
            end
            if ((w_next == ST_GAP) || (w_next == ST_IDLE)) begin
                r_oe      <= 1'b0;
                r_do      <= 4'h0;
                r_rd_seen <= 1'b0;
            end

            // Nibbles are captured on the last cycle of each half, just before the CLK edge.
            if ((r_state == ST_LOW) && w_tc && r_dir) r_rx[7:4] <= qpi_io_di;
            if ((r_state == ST_HIGH) && w_tc && r_dir) r_rx[3:0] <= qpi_io_di;
            r_rd_pend  <= (r_state == ST_HIGH) && w_tc && r_dir;
            r_rd_valid <= r_rd_pend;
            if (r_rd_pend) r_rd_data <= r_rx;
        end
    end

    assign xfer_ready = r_ready;
    assign busy       = r_busy;
    assign rd_valid   = r_rd_valid;
    assign rd_data    = r_rd_data;
    assign qpi_csb_do = r_csb;
    assign qpi_clk_do = r_clk;
    assign qpi_io_do  = r_do;
    assign qpi_io_oe  = {4{r_oe}};

endmodule

// File: tb/tb_mlaccel_qpi_master.sv
// Directed bench for mlaccel_qpi_master with a QPI slave model, a write-capture
// scoreboard and a second instance at the maximum divider/gap settings.
module tb_mlaccel_qpi_master;

    localparam int CLKDIV  = 4;
    localparam int CSB_GAP = 8;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic resetn;
    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- DUT (default timing) ----------------
    logic       xfer_valid, xfer_start, xfer_last, xfer_dir;
    logic [7:0] xfer_data;
    logic       xfer_ready, rd_valid, busy, qpi_csb_do, qpi_clk_do;
    logic [7:0] rd_data;
    logic [3:0] qpi_io_do, qpi_io_oe, qpi_io_di;
    logic [7:0] slave_byte;

    mlaccel_qpi_master #(.CLKDIV(CLKDIV), .CSB_GAP(CSB_GAP)) u_dut (
        .clock      (clock),
        .resetn     (resetn),
        .xfer_valid (xfer_valid),
        .xfer_ready (xfer_ready),
        .xfer_start (xfer_start),
        .xfer_last  (xfer_last),
        .xfer_dir   (xfer_dir),
        .xfer_data  (xfer_data),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .busy       (busy),
        .qpi_csb_do (qpi_csb_do),
        .qpi_clk_do (qpi_clk_do),
        .qpi_io_do  (qpi_io_do),
        .qpi_io_oe  (qpi_io_oe),
        .qpi_io_di  (qpi_io_di)
    );

    // Slave presents the high nibble while CLK is low and the low nibble while high.
    assign qpi_io_di = qpi_clk_do ? slave_byte[3:0] : slave_byte[7:4];

    // ---------------- DUT (maximum divider and gap) ----------------
    logic       b_valid, b_start, b_last, b_dir;
    logic [7:0] b_data;
    logic       b_ready, b_rd_valid, b_busy, b_csb, b_clk;
    logic [7:0] b_rd_data;
    logic [3:0] b_io_do, b_io_oe, b_io_di;

    mlaccel_qpi_master #(.CLKDIV(255), .CSB_GAP(255)) u_big (
        .clock      (clock),
        .resetn     (resetn),
        .xfer_valid (b_valid),
        .xfer_ready (b_ready),
        .xfer_start (b_start),
        .xfer_last  (b_last),
        .xfer_dir   (b_dir),
        .xfer_data  (b_data),
        .rd_valid   (b_rd_valid),
        .rd_data    (b_rd_data),
        .busy       (b_busy),
        .qpi_csb_do (b_csb),
        .qpi_clk_do (b_clk),
        .qpi_io_do  (b_io_do),
        .qpi_io_oe  (b_io_oe),
        .qpi_io_di  (b_io_di)
    );
    assign b_io_di = 4'h0;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] cap_q[$];
    logic [7:0] rd_exp_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] b_exp_q[$];
    logic [7:0] b_cap_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- slave / pin monitor ----------------
    logic        p_clk = 1'b0, p_csb = 1'b1;
    logic [3:0]  p_io = 4'h0, p_oe = 4'h0, hi_nib = 4'h0;
    logic        wr_byte = 1'b0, slave_drv = 1'b0, arm_rise = 1'b0;
    int          rises = 0, rd_cnt = 0, contention = 0;
    int          low_run = 0, high_run = 0, last_low_run = 0, last_high_run = 0;
    int unsigned fall_cyc = 0, acc_cyc = 0, first_rise_lat = 0, rd_lat = 0;

    always @(negedge clock) begin
        if (!qpi_csb_do && qpi_clk_do && !p_clk) begin
            rises++;
            if (arm_rise) begin
                first_rise_lat = cyc - acc_cyc;
                arm_rise = 1'b0;
            end
            wr_byte = (p_oe == 4'hf);
            hi_nib  = p_io;
            if (p_oe == 4'h0) slave_drv = 1'b1;
        end
        if (!qpi_csb_do && !qpi_clk_do && p_clk) begin
            fall_cyc = cyc;
            if (wr_byte && p_oe == 4'hf) cap_q.push_back({hi_nib, p_io});
        end
        if (qpi_csb_do) slave_drv = 1'b0;
        if (slave_drv && qpi_io_oe != 4'h0) contention++;
        if (rd_valid) begin
            rd_cnt++;
            rd_q.push_back(rd_data);
            rd_lat = cyc - fall_cyc;
        end
        if (!qpi_csb_do) begin
            if (p_csb) begin
                last_high_run = high_run;
                high_run = 0;
            end
            low_run++;
        end else begin
            if (!p_csb) begin
                last_low_run = low_run;
                low_run = 0;
            end
            high_run++;
        end
        p_clk = qpi_clk_do;
        p_csb = qpi_csb_do;
        p_io  = qpi_io_do;
        p_oe  = qpi_io_oe;
    end

    logic        bp_clk = 1'b0, b_done = 1'b0;
    logic [3:0]  bp_io = 4'h0, b_hi = 4'h0;
    int unsigned b_rise_cyc = 0, b_fall_cyc = 0;

    always @(negedge clock) begin
        if (!b_csb && b_clk && !bp_clk) begin
            b_rise_cyc = cyc;
            b_hi = bp_io;
        end
        if (!b_csb && !b_clk && bp_clk) begin
            b_fall_cyc = cyc;
            b_cap_q.push_back({b_hi, bp_io});
            b_done = 1'b1;
        end
        bp_clk = b_clk;
        bp_io  = b_io_do;
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic st, input logic last, input logic dir, input logic [7:0] d);
        bit ok = 1'b0;
        @(negedge clock);
        xfer_valid = 1'b1;
        xfer_start = st;
        xfer_last  = last;
        xfer_dir   = dir;
        xfer_data  = d;
        for (int i = 0; i < 4000; i++) begin
            if (xfer_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!ok) chk("accept_timeout", xfer_ready, 1'b1);
        @(posedge clock);
        #1;
        acc_cyc    = cyc;
        xfer_valid = 1'b0;
        if (!dir) exp_q.push_back(d);
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            if (!busy && !big_busy()) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk(tag, busy, 1'b0);
        repeat (2) @(negedge clock);
    endtask

    function automatic bit big_busy();
        return b_busy;
    endfunction

    task automatic drain(input string tag);
        logic [7:0] e, c;
        chk({tag, "_count"}, cap_q.size(), exp_q.size());
        while (exp_q.size() > 0 && cap_q.size() > 0) begin
            e = exp_q.pop_front();
            c = cap_q.pop_front();
            chk({tag, "_byte"}, c, e);
        end
        exp_q.delete();
        cap_q.delete();
    endtask

    task automatic drain_rd(input string tag);
        logic [7:0] e, c;
        chk({tag, "_count"}, rd_q.size(), rd_exp_q.size());
        while (rd_exp_q.size() > 0 && rd_q.size() > 0) begin
            e = rd_exp_q.pop_front();
            c = rd_q.pop_front();
            chk({tag, "_data"}, c, e);
        end
        rd_exp_q.delete();
        rd_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int pin_bad;
        int r0, rd0, b_ok;

        resetn = 1'b0;
        xfer_valid = 1'b0; xfer_start = 1'b0; xfer_last = 1'b0; xfer_dir = 1'b0;
        xfer_data = 8'h00; slave_byte = 8'h00;
        b_valid = 1'b0; b_start = 1'b0; b_last = 1'b0; b_dir = 1'b0; b_data = 8'h00;

        // Reset values
        repeat (3) @(negedge clock);
        chk("rst_csb", qpi_csb_do, 1'b1);
        chk("rst_clk", qpi_clk_do, 1'b0);
        chk("rst_oe", qpi_io_oe, 4'h0);
        chk("rst_do", qpi_io_do, 4'h0);
        chk("rst_ready", xfer_ready, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        resetn = 1'b1;
        @(negedge clock);
        chk("ready_after_release", xfer_ready, 1'b1);

        // Idle for 100 cycles: pins stay quiet
        pin_bad = 0;
        repeat (100) begin
            @(negedge clock);
            if (qpi_csb_do !== 1'b1 || qpi_clk_do !== 1'b0 || qpi_io_oe !== 4'h0) pin_bad++;
        end
        chk("idle_pins", pin_bad, 0);
        chk("idle_ready", xfer_ready, 1'b1);

        // Three-byte write frame, bytes issued back to back
        r0 = rises;
        arm_rise = 1'b1;
        send(1'b1, 1'b0, 1'b0, 8'h25);
        send(1'b0, 1'b0, 1'b0, 8'h34);
        send(1'b0, 1'b1, 1'b0, 8'h12);
        wait_idle("wr3_idle");
        drain("wr3");
        chk("wr3_rises", rises - r0, 3);
        // LEAD + three bytes + one WAIT cycle between bytes + TAIL
        chk("wr3_csb_low", last_low_run, CLKDIV + 3 * 2 * CLKDIV + 2 + CLKDIV);
        // Counted inclusive of the accept cycle itself
        chk("accept_to_rise", first_rise_lat + 1, CSB_GAP + 2 * CLKDIV + 1);

        // Command byte followed by a read in the same frame
        slave_byte = 8'hA5;
        rd0 = rd_cnt;
        contention = 0;
        send(1'b1, 1'b0, 1'b0, 8'h20);
        send(1'b0, 1'b1, 1'b1, 8'h00);
        rd_exp_q.push_back(8'hA5);
        wait_idle("rd_idle");
        chk("rd_pulses", rd_cnt - rd0, 1);
        chk("rd_latency", rd_lat, 1);
        drain_rd("rd");
        drain("rd_cmd");
        chk("rd_no_contention", contention, 0);
        chk("rd_data_held", rd_data, 8'hA5);

        // Read then write without start: the write must reopen the frame
        slave_byte = 8'h3C;
        r0 = rises;
        contention = 0;
        send(1'b1, 1'b0, 1'b1, 8'h00);
        rd_exp_q.push_back(8'h3C);
        send(1'b0, 1'b1, 1'b0, 8'h21);
        wait_idle("turn_idle");
        drain_rd("turn_rd");
        drain("turn_wr");
        chk("turn_gap", last_high_run, CSB_GAP);
        chk("turn_rises", rises - r0, 2);
        chk("turn_no_contention", contention, 0);

        // Reset asserted during the HIGH phase of a write
        rd0 = rd_cnt;
        send(1'b1, 1'b1, 1'b0, 8'h77);
        b_ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (qpi_clk_do) begin
                b_ok = 1;
                break;
            end
        end
        if (b_ok == 0) chk("reset_wait_high", qpi_clk_do, 1'b1);
        @(negedge clock);
        resetn = 1'b0;
        #1;
        chk("midrst_csb", qpi_csb_do, 1'b1);
        chk("midrst_clk", qpi_clk_do, 1'b0);
        chk("midrst_oe", qpi_io_oe, 4'h0);
        chk("midrst_do", qpi_io_do, 4'h0);
        chk("midrst_busy", busy, 1'b0);
        void'(exp_q.pop_back());
        @(negedge clock);
        resetn = 1'b1;
        repeat (20) @(negedge clock);
        chk("midrst_no_rd_valid", rd_cnt - rd0, 0);
        chk("midrst_no_capture", cap_q.size(), 0);
        send(1'b1, 1'b1, 1'b0, 8'h26);
        wait_idle("post_rst_idle");
        drain("post_rst");

        // Maximum divider and gap: one write byte
        b_done = 1'b0;
        @(negedge clock);
        b_valid = 1'b1; b_start = 1'b1; b_last = 1'b1; b_dir = 1'b0; b_data = 8'h5A;
        b_exp_q.push_back(8'h5A);
        @(posedge clock);
        #1;
        acc_cyc = cyc;
        b_valid = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if (b_done) break;
        end
        chk("big_done", b_done, 1'b1);
        chk("big_high_half", b_fall_cyc - b_rise_cyc, 255);
        chk("big_accept_to_rise", b_rise_cyc - acc_cyc + 1, 255 + 2 * 255 + 1);
        chk("big_cap_count", b_cap_q.size(), b_exp_q.size());
        if (b_cap_q.size() > 0 && b_exp_q.size() > 0) chk("big_byte", b_cap_q.pop_front(), b_exp_q.pop_front());
        wait_idle("big_idle");
        chk("big_csb_idle", b_csb, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
